data_memory_bytelane: RTL and testbench

//  Next-generation RV32 data memory: byte-addressable, little-endian, sized loads/stores (funct3 encoded),

---
 rtl/data_memory_bytelane.sv | 188 ++++++++++++++++++
 tb/tb_data_memory_bytelane.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytelane.sv
// RV32 byte-lane data memory: sized little-endian loads/stores, valid/ready request, timed response pulse.
// Build option MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being force-aligned.
module data_memory_bytelane #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST_WAIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] pend_rdata;
  logic        pend_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          size_bad;
  logic          range_bad;
  logic          req_err;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_ext;
  logic [31:0]   ld_result;

  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[AW+1:2];
  assign range_bad = |req_addr[31:AW+2];

  // Lane is derived from the size-aligned address; when trapping, misaligned cases fault anyway.
  always_comb begin
    lane = req_addr[1:0];
    case (req_size)
      F_H, F_HU: lane = {req_addr[1], 1'b0};
      F_W:       lane = 2'b00;
      default:   lane = req_addr[1:0];
    endcase
  end

  always_comb begin
    size_bad = 1'b1;
    case (req_size)
      F_B, F_H, F_W: size_bad = 1'b0;
      F_BU, F_HU:    size_bad = req_we;
      default:       size_bad = 1'b1;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      F_H, F_HU: misalign = req_addr[0];
      F_W:       misalign = |req_addr[1:0];
      default:   misalign = 1'b0;
    endcase
  end

  assign req_err = size_bad | range_bad | misalign;
`else
  assign req_err = size_bad | range_bad;
`endif

  always_comb begin
    byte_en = '0;
    case (req_size)
      F_B:     byte_en = 4'b0001 << lane;
      F_H:     byte_en = 4'b0011 << lane;
      F_W:     byte_en = 4'b1111;
      default: byte_en = '0;
    endcase
  end

  assign wr_data  = req_wdata << {lane, 3'b000};
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_ext = '0;
    case (req_size)
      F_B:     ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F_BU:    ld_ext = {24'd0, rd_shift[7:0]};
      F_H:     ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F_HU:    ld_ext = {16'd0, rd_shift[15:0]};
      F_W:     ld_ext = rd_shift;
      default: ld_ext = '0;
    endcase
  end

  assign ld_result = (req_err || req_we) ? '0 : ld_ext;

  // Stores commit at the accept edge so a load accepted later observes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (accept && req_we && !req_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // The result is formed at accept and parked in pend_* so rsp_* keep the
  // previous response until the new response cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= ld_result;
              rsp_err   <= req_err;
            end else begin
              state      <= ST_WAIT;
              wait_cnt   <= '0;
              pend_rdata <= ld_result;
              pend_err   <= req_err;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_rdata;
            rsp_err   <= pend_err;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench for data_memory_bytelane: a WAIT_STATES=3 instance for function and a
// WAIT_STATES=0 instance for minimum latency; expectations are queued at drive time.
module tb_data_memory_bytelane;

  localparam int unsigned WS    = 3;
  localparam int unsigned DEPTH = 256;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] WORD10_FINAL = 32'h123455EF;
`else
  localparam logic [31:0] WORD10_FINAL = 32'h1234BEEF;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = 3'b010;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_valid = 1'b0;
  logic        z_ready;
  logic        z_we = 1'b0;
  logic [31:0] z_addr = '0;
  logic [2:0]  z_size = 3'b010;
  logic [31:0] z_wdata = '0;
  logic        z_rsp_valid;
  logic [31:0] z_rdata;
  logic        z_err;

  exp_t        sb_q[$];
  exp_t        sbz_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
    .req_addr(z_addr), .req_size(z_size), .req_wdata(z_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err)
  );

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b at cyc %0d, expected no response", rsp_rdata, rsp_err, cyc);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc !== e.due) begin
          miscompares++;
          $display("FAIL rsp_check: got rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d",
                   rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && z_rsp_valid) begin
      vectors++;
      if (sbz_q.size() == 0) begin
        miscompares++;
        $display("FAIL zrsp_unexpected: got rdata=%h err=%b at cyc %0d, expected no response", z_rdata, z_err, cyc);
      end else begin
        e = sbz_q.pop_front();
        if (z_rdata !== e.rdata || z_err !== e.err || cyc !== e.due) begin
          miscompares++;
          $display("FAIL zrsp_check: got rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d",
                   z_rdata, z_err, cyc, e.rdata, e.err, e.due);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    exp_t e;
    int unsigned n = 0;
    while (req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_size  = size;
      req_wdata = wdata;
      e.rdata = er;
      e.err   = ee;
      e.due   = cyc + 1 + WS;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_size  = 3'b011;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain_z();
    int unsigned n = 0;
    while (sbz_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbz_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL zdrain_timeout: got %0d responses outstanding, expected 0", sbz_q.size());
      sbz_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, expected 1", req_ready);
    end
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b, expected 0/00000000/0", rsp_valid, rsp_rdata, rsp_err);
    end
    vectors++;
    if (z_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_z: got ready=%b valid=%b, expected 1/0", z_ready, z_rsp_valid);
    end
    issue(1'b0, 32'h000, F_W, '0, 32'h0, 1'b0);
    issue(1'b0, 32'h3FC, F_W, '0, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_sized_access();
    issue(1'b1, 32'h10, F_W,  32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, 32'h10, F_B,  '0, 32'hFFFFFFEF, 1'b0);
    issue(1'b0, 32'h13, F_BU, '0, 32'h000000DE, 1'b0);
    issue(1'b0, 32'h12, F_H,  '0, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 32'h10, F_HU, '0, 32'h0000BEEF, 1'b0);
    issue(1'b0, 32'h11, F_B,  '0, 32'hFFFFFFBE, 1'b0);
    issue(1'b0, 32'h12, F_BU, '0, 32'h000000AD, 1'b0);
    issue(1'b0, 32'h10, F_H,  '0, 32'hFFFFBEEF, 1'b0);
    issue(1'b0, 32'h12, F_HU, '0, 32'h0000DEAD, 1'b0);
    issue(1'b0, 32'h10, F_W,  '0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 32'h11, F_B,  32'hFFFFFF55, 32'h0, 1'b0);
    issue(1'b0, 32'h10, F_W,  '0, 32'hDEAD55EF, 1'b0);
    issue(1'b1, 32'h12, F_H,  32'hABCD1234, 32'h0, 1'b0);
    issue(1'b0, 32'h10, F_W,  '0, 32'h123455EF, 1'b0);
    issue(1'b1, 32'h17, F_B,  32'h00000080, 32'h0, 1'b0);
    issue(1'b0, 32'h17, F_B,  '0, 32'hFFFFFF80, 1'b0);
    issue(1'b0, 32'h14, F_W,  '0, 32'h80000000, 1'b0);
    issue(1'b1, 32'h3FC, F_W, 32'h01020304, 32'h0, 1'b0);
    issue(1'b0, 32'h3FC, F_W, '0, 32'h01020304, 1'b0);
    issue(1'b0, 32'h3FF, F_BU, '0, 32'h00000001, 1'b0);
    issue(1'b1, 32'h20, F_H,  32'h00007F00, 32'h0, 1'b0);
    issue(1'b0, 32'h20, F_H,  '0, 32'h00007F00, 1'b0);
    issue(1'b0, 32'h21, F_B,  '0, 32'h0000007F, 1'b0);
    issue(1'b0, 32'h20, F_BU, '0, 32'h00000000, 1'b0);
    drain();
  endtask

  task automatic test_errors();
    issue(1'b0, 32'h400,      F_W,    '0, 32'h0, 1'b1);
    issue(1'b1, 32'h400,      F_W,    32'hFFFFFFFF, 32'h0, 1'b1);
    issue(1'b0, 32'h000,      F_W,    '0, 32'h0, 1'b0);
    issue(1'b0, 32'hFFFFFFFC, F_W,    '0, 32'h0, 1'b1);
    issue(1'b0, 32'h10,       3'b011, '0, 32'h0, 1'b1);
    issue(1'b0, 32'h10,       3'b110, '0, 32'h0, 1'b1);
    issue(1'b0, 32'h10,       3'b111, '0, 32'h0, 1'b1);
    issue(1'b1, 32'h10,       3'b011, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 32'h10,       F_BU,   32'h0, 32'h0, 1'b1);
    issue(1'b1, 32'h10,       F_HU,   32'h0, 32'h0, 1'b1);
    issue(1'b0, 32'h10,       F_W,    '0, 32'h123455EF, 1'b0);
    drain();
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 32'h12, F_W,  '0, 32'h0, 1'b1);
    issue(1'b0, 32'h11, F_H,  '0, 32'h0, 1'b1);
    issue(1'b0, 32'h13, F_HU, '0, 32'h0, 1'b1);
    issue(1'b1, 32'h11, F_H,  32'h0000BEEF, 32'h0, 1'b1);
    issue(1'b1, 32'h12, F_W,  32'hFFFFFFFF, 32'h0, 1'b1);
`else
    issue(1'b0, 32'h12, F_W,  '0, 32'h123455EF, 1'b0);
    issue(1'b0, 32'h13, F_H,  '0, 32'h00001234, 1'b0);
    issue(1'b0, 32'h11, F_HU, '0, 32'h000055EF, 1'b0);
    issue(1'b1, 32'h11, F_H,  32'h0000BEEF, 32'h0, 1'b0);
`endif
    issue(1'b0, 32'h10, F_W, '0, WORD10_FINAL, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle_ready: got %b, expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h3FC;
    req_size  = F_W;
    req_wdata = '0;
    e.rdata = 32'h01020304;
    e.err   = 1'b0;
    e.due   = cyc + 1 + WS;
    sb_q.push_back(e);
    for (int i = 0; i <= int'(WS); i++) begin
      @(negedge clk);
      req_addr = 32'h10;
      vectors++;
      if (req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_busy_ready: got %b at busy cycle %0d, expected 0", req_ready, i);
      end
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_reready: got %b, expected 1", req_ready);
    end
    e.rdata = WORD10_FINAL;
    e.err   = 1'b0;
    e.due   = cyc + 1 + WS;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_zero_wait();
    exp_t e;
    vectors++;
    if (z_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_idle_ready: got %b, expected 1", z_ready);
    end
    z_valid = 1'b1;
    z_we    = 1'b1;
    z_addr  = 32'h8;
    z_size  = F_W;
    z_wdata = 32'hA5A5A5A5;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.due   = cyc + 1;
    sbz_q.push_back(e);
    @(negedge clk);
    vectors++;
    if (z_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_busy_ready: got %b, expected 0", z_ready);
    end
    z_we   = 1'b0;
    z_size = F_B;
    z_addr = 32'h9;
    @(negedge clk);
    vectors++;
    if (z_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_reready: got %b, expected 1", z_ready);
    end
    e.rdata = 32'hFFFFFFA5;
    e.err   = 1'b0;
    e.due   = cyc + 1;
    sbz_q.push_back(e);
    @(negedge clk);
    vectors++;
    if (z_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_busy2_ready: got %b, expected 0", z_ready);
    end
    z_valid = 1'b0;
    drain_z();
  endtask

  task automatic test_reset_abort();
    logic seen = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_size  = F_W;
    req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (WS + 3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_rsp: got rsp_valid pulse after reset, expected none");
    end
    issue(1'b0, 32'h30, F_W, '0, 32'h0, 1'b0);
    issue(1'b0, 32'h10, F_W, '0, 32'h0, 1'b0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sized_access();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_zero_wait();
    test_reset_abort();
    drain();
    drain_z();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
